// File: rtl/serial_frame_if.sv
// Handshake bundle between the pulse-identifier channels, the frame arbiter
// and the uart_tx byte transmitter.
interface serial_frame_if #(
    parameter int N_SRC   = 2,
    parameter int PULSE_W = 17
);
    logic [N_SRC-1:0]           req;
    logic [N_SRC*3*PULSE_W-1:0] fields;
    logic [N_SRC-1:0]           ack;
    logic [7:0]                 tx_data;
    logic                       tx_start;
    logic                       tx_ready;
    logic                       busy;
    logic [2:0]                 grant_id;

    // Arbiter side: consumes requests and tx_ready, drives acks and the byte stream.
    modport master (
        input  req, fields, tx_ready,
        output ack, tx_data, tx_start, busy, grant_id
    );

    // Environment side: channels and transmitter.
    modport slave (
        output req, fields, tx_ready,
        input  ack, tx_data, tx_start, busy, grant_id
    );
endinterface

// File: rtl/serial_frame_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_SRC pulse-identifier
// channels. The winner's three fields are latched into a shadow register and
// sent as one frame: SYNC_BYTES x 0x00, {5'b0, id}, then pulse_id_0,
// pulse_id_1 and polynomial as 3 bytes each, MSB first.
// Interface widths must match N_SRC / PULSE_W given here.
module serial_frame_arbiter #(
    parameter int N_SRC      = 2,
    parameter int PULSE_W    = 17,
    parameter int SYNC_BYTES = 4
) (
    input  logic              clk_12MHz,
    input  logic              reset,
    serial_frame_if.master    bus
);
    localparam int FW   = 3 * PULSE_W;
    localparam int LAST = SYNC_BYTES + 9;   // index of the final frame byte

    typedef enum logic [2:0] {IDLE, GRANT, SEND, WAIT_LOW, DRAIN} state_t;

    state_t          state;
    logic [2:0]      rr_ptr;
    logic [4:0]      byte_cnt;
    logic [FW-1:0]   shadow;

    logic            found;
    logic [2:0]      pick;
    logic [FW-1:0]   pick_fields;
    logic [23:0]     ext0, ext1, ext2;
    logic [79:0]     payload;
    logic [7:0]      cur_byte;

    // Round-robin scan starting just after the last served channel.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (!found && bus.req[i] && i == (int'(rr_ptr) + k) % N_SRC) begin
                    found = 1'b1;
                    pick  = 3'(i);
                end
            end
        end
    end

    // Mux out the winner's field group for the shadow register.
    always_comb begin
        pick_fields = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (pick == 3'(i)) pick_fields = bus.fields[i*FW +: FW];
        end
    end

    // Frame byte for the current byte_cnt; fields are zero-extended to 24 bits.
    always_comb begin
        ext0 = '0;
        ext1 = '0;
        ext2 = '0;
        ext0[PULSE_W-1:0] = shadow[PULSE_W-1:0];
        ext1[PULSE_W-1:0] = shadow[2*PULSE_W-1:PULSE_W];
        ext2[PULSE_W-1:0] = shadow[3*PULSE_W-1:2*PULSE_W];
        payload = {5'b0, bus.grant_id, ext0, ext1, ext2};
        if (byte_cnt < 5'(SYNC_BYTES)) cur_byte = 8'h00;
        else                           cur_byte = payload[8*(LAST - int'(byte_cnt)) +: 8];
    end

    // Control FSM with registered outputs. tx_data is loaded together with
    // tx_start, so it never moves while the transmitter is busy.
    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= 3'(N_SRC - 1);
            byte_cnt     <= '0;
            shadow       <= '0;
            bus.ack      <= '0;
            bus.tx_start <= 1'b0;
            bus.tx_data  <= 8'h00;
            bus.busy     <= 1'b0;
            bus.grant_id <= '0;
        end else begin
            bus.ack      <= '0;
            bus.tx_start <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    shadow       <= pick_fields;
                    bus.grant_id <= pick;
                    for (int i = 0; i < N_SRC; i++) bus.ack[i] <= (pick == 3'(i));
                    bus.busy     <= 1'b1;
                    rr_ptr       <= pick;
                    state        <= GRANT;
                end
                GRANT: begin
                    byte_cnt <= '0;
                    state    <= SEND;
                end
                SEND: if (bus.tx_ready) begin
                    bus.tx_data  <= cur_byte;
                    bus.tx_start <= 1'b1;
                    state        <= WAIT_LOW;
                end
                WAIT_LOW: if (!bus.tx_ready) begin
                    if (byte_cnt < 5'(LAST)) begin
                        byte_cnt <= byte_cnt + 5'd1;
                        state    <= SEND;
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: if (bus.tx_ready) begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_frame_arbiter.sv
// Bench for serial_frame_arbiter: uart_tx ready model, byte/ack monitor,
// table of frame vectors, directed corner sequences and random frames
// checked against a frame/round-robin reference model.
module tb_serial_frame_arbiter;
    localparam int N  = 2;
    localparam int W  = 17;
    localparam int S  = 4;
    localparam int FV = N * 3 * W;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [N-1:0] req;
        bit           pulse;
        int           exp_id;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    serial_frame_if #(.N_SRC(N), .PULSE_W(W)) bus();

    serial_frame_arbiter #(.N_SRC(N), .PULSE_W(W), .SYNC_BYTES(S)) dut (
        .clk_12MHz(clk),
        .reset(reset),
        .bus(bus.master)
    );

    int        n_vec = 0;
    int        n_err = 0;
    int        lo_min = 1;
    int        lo_max = 3;
    bit        stuck = 1'b0;
    logic [7:0] got[$];
    int        ack_q[$];
    logic [7:0] last_data = 8'h00;
    int        win_starts = 0;
    int        model_last = N - 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: round-robin winner = requester at smallest distance after last.
    function automatic int pick(input logic [N-1:0] r, input int last);
        int best, bd, d;
        best = -1;
        bd = N;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                d = (i - last - 1 + N) % N;
                if (d < bd) begin
                    bd = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    // Reference: expected frame bytes for a channel id and its field group.
    function automatic bq_t frame_of(input int id, input logic [3*W-1:0] f);
        bq_t q;
        int v;
        for (int s = 0; s < S; s++) q.push_back(8'h00);
        q.push_back(8'(id));
        for (int j = 0; j < 3; j++) begin
            v = int'(f[j*W +: W]);
            q.push_back(8'(v / 65536));
            q.push_back(8'((v / 256) % 256));
            q.push_back(8'(v % 256));
        end
        return q;
    endfunction

    function automatic logic [FV-1:0] rand_fields();
        logic [FV-1:0] f;
        for (int i = 0; i < 3 * N; i++) f[i*W +: W] = W'($urandom);
        return f;
    endfunction

    // uart_tx model: ready drops right after a start and stays low a random time.
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (stuck) bus.tx_ready = 1'b0;
            else if (bus.tx_start) begin
                bus.tx_ready = 1'b0;
                repeat ($urandom_range(lo_max, lo_min)) @(negedge clk);
                bus.tx_ready = 1'b1;
            end else bus.tx_ready = 1'b1;
        end
    end

    // Monitor: collects bytes and acks, checks handshake rules every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                last_data  = 8'h00;
                win_starts = 0;
            end else begin
                if (bus.tx_start) begin
                    got.push_back(bus.tx_data);
                    last_data = bus.tx_data;
                    chk("start_in_ready_window", 32'(bus.tx_ready && win_starts == 0), 1);
                    win_starts++;
                end else if (!bus.tx_ready) win_starts = 0;
                if (bus.busy && !bus.tx_ready) chk("tx_data_stable", bus.tx_data, last_data);
                if (bus.ack != '0) begin
                    chk("ack_onehot", 32'($onehot(bus.ack)), 1);
                    for (int i = 0; i < N; i++) if (bus.ack[i]) ack_q.push_back(i);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset(input int cycles, input string tag);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #3;
        chk({tag, "_tx_start"}, 32'(bus.tx_start), 0);
        chk({tag, "_busy"},     32'(bus.busy), 0);
        chk({tag, "_ack"},      32'(bus.ack), 0);
        chk({tag, "_tx_data"},  32'(bus.tx_data), 0);
        chk({tag, "_grant_id"}, 32'(bus.grant_id), 0);
        reset = 1'b0;
        model_last = N - 1;
    endtask

    // One full frame: drive request, check ack/grant, scramble fields, check bytes.
    task automatic do_frame(input logic [N-1:0] r, input bit pulse, input int exp_id,
                            input logic [FV-1:0] fv, input int late_at,
                            input logic [N-1:0] late_req, input string tag);
        bq_t exp;
        int  cnt;
        bit  late_done;
        late_done = 1'b0;
        got.delete();
        ack_q.delete();
        bus.fields = fv;
        bus.req = r;
        exp = frame_of(exp_id, fv[exp_id*3*W +: 3*W]);
        cnt = 0;
        while (ack_q.size() == 0 && cnt < 8) begin
            tick();
            if (pulse) bus.req = '0;
            cnt++;
        end
        chk({tag, "_ack_seen"}, ack_q.size(), 1);
        if (ack_q.size() != 0) chk({tag, "_grant"}, ack_q[0], exp_id);
        bus.fields = ~fv;
        cnt = 0;
        while (bus.busy && cnt < 6000) begin
            tick();
            cnt++;
            if (!late_done && late_at >= 0 && got.size() >= late_at) begin
                bus.req = late_req;
                late_done = 1'b1;
            end
        end
        chk({tag, "_done"}, 32'(bus.busy), 0);
        chk({tag, "_len"}, got.size(), exp.size());
        for (int b = 0; b < exp.size() && b < got.size(); b++)
            chk($sformatf("%s_byte%0d", tag, b), got[b], exp[b]);
        chk({tag, "_acks"}, ack_q.size(), 1);
        chk({tag, "_grant_id"}, 32'(bus.grant_id), exp_id);
        model_last = exp_id;
    endtask

    initial begin
        vec_t          tbl[8];
        logic [7:0]    spec_bytes[14];
        logic [FV-1:0] fv;
        logic [N-1:0]  r;
        int            e, cnt;

        tbl[0] = '{2'b11, 1'b0, 0};
        tbl[1] = '{2'b11, 1'b0, 1};
        tbl[2] = '{2'b11, 1'b0, 0};
        tbl[3] = '{2'b10, 1'b1, 1};
        tbl[4] = '{2'b10, 1'b0, 1};
        tbl[5] = '{2'b11, 1'b0, 0};
        tbl[6] = '{2'b01, 1'b1, 0};
        tbl[7] = '{2'b11, 1'b0, 1};
        spec_bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                       8'h23, 8'h01, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h0F};

        bus.req = '0;
        bus.fields = '0;

        // Reset state.
        do_reset(3, "reset");

        // Single channel, known fields, explicit byte list.
        fv = '0;
        fv[0 +: W]   = W'(32'h00123);
        fv[W +: W]   = W'(32'h1ABCD);
        fv[2*W +: W] = W'(32'h0000F);
        do_frame(2'b01, 1'b0, 0, fv, -1, '0, "spec");
        bus.req = '0;
        for (int b = 0; b < 14 && b < got.size(); b++)
            chk($sformatf("spec_literal%0d", b), got[b], spec_bytes[b]);

        // Table vectors: contention order, single requesters, 1-cycle pulses.
        do_reset(1, "pre_table");
        for (int i = 0; i < 8; i++)
            do_frame(tbl[i].req, tbl[i].pulse, tbl[i].exp_id, rand_fields(), -1, '0,
                     $sformatf("tbl%0d", i));
        bus.req = '0;

        // Handshake stress: long ready-low windows.
        lo_min = 10;
        lo_max = 200;
        for (int i = 0; i < 2; i++) begin
            r = 2'b11;
            do_frame(r, 1'b0, pick(r, model_last), rand_fields(), -1, '0, $sformatf("stress%0d", i));
        end
        bus.req = '0;
        lo_min = 1;
        lo_max = 3;

        // Late request during a channel-0 frame.
        do_frame(2'b01, 1'b0, 0, rand_fields(), 5, 2'b10, "late0");
        do_frame(2'b10, 1'b0, 1, rand_fields(), -1, '0, "late1");
        bus.req = '0;

        // Reset in the middle of a frame.
        got.delete();
        ack_q.delete();
        bus.fields = rand_fields();
        bus.req = 2'b10;
        cnt = 0;
        while (got.size() < 8 && cnt < 3000) begin
            tick();
            cnt++;
        end
        chk("mid_reached_byte8", 32'(got.size() >= 8), 1);
        bus.req = '0;
        do_reset(1, "midreset");
        do_frame(2'b11, 1'b0, 0, rand_fields(), -1, '0, "after_reset");
        bus.req = '0;

        // tx_ready stuck low: frame stalls until reset.
        stuck = 1'b1;
        tick();
        tick();
        got.delete();
        ack_q.delete();
        bus.fields = rand_fields();
        bus.req = 2'b01;
        repeat (300) tick();
        bus.req = '0;
        chk("stuck_acks", ack_q.size(), 1);
        chk("stuck_busy", 32'(bus.busy), 1);
        chk("stuck_no_bytes", got.size(), 0);
        do_reset(1, "stuck_reset");
        stuck = 1'b0;
        tick();

        // Random frames against the reference model.
        lo_min = 1;
        lo_max = 6;
        for (int i = 0; i < 12; i++) begin
            r = N'($urandom_range(3, 1));
            e = pick(r, model_last);
            do_frame(r, 1'($urandom_range(1, 0)), e, rand_fields(), -1, '0, $sformatf("rnd%0d", i));
        end
        bus.req = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
